// File: rtl/cabac_ctx_ram_ctrl_pkg.sv
// Shared types and defaults for the CABAC context SRAM controller.
// Optional build macro: CABAC_CTX_RSP_REG_EN (registered read response).
package cabac_ctx_ram_ctrl_pkg;

  localparam int CABAC_CTX_ADDR_W = 6;
  localparam int CABAC_CTX_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/cabac_ctx_ram_ctrl_init_seq.sv
// Init sweep counter with busy/done flags.
// Any start pulse restarts the sweep from entry 0.
module cabac_ctx_ram_ctrl_init_seq
  import cabac_ctx_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = CABAC_CTX_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  assign last_o = busy_q && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (last_o) begin
      // hold at the last entry so the address never leaves range
      busy_q <= 1'b0;
      done_q <= 1'b1;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign addr_o = cnt_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/cabac_ctx_ram_ctrl.sv
// CABAC context SRAM client controller: init sweep, request port, read response.
// Optional build macro: CABAC_CTX_RSP_REG_EN adds a response output register.
module cabac_ctx_ram_ctrl
  import cabac_ctx_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = CABAC_CTX_ADDR_W,
  parameter int DATA_W = CABAC_CTX_DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start_i,
  output logic              init_busy_o,
  output logic              init_done_o,
  output logic [ADDR_W-1:0] init_addr_o,
  input  logic [DATA_W-1:0] init_data_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  ctx_state_e state_q;
  logic       init_last;
  logic       xfer;
  logic       rd_q;

  cabac_ctx_ram_ctrl_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk     (clk),
    .rst     (rst),
    .start_i (init_start_i),
    .addr_o  (init_addr_o),
    .busy_o  (init_busy_o),
    .done_o  (init_done_o),
    .last_o  (init_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (init_start_i) state_q <= ST_INIT;
        ST_INIT: if (!init_start_i && init_last) state_q <= ST_RUN;
        ST_RUN:  if (init_start_i) state_q <= ST_INIT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_RUN);
  assign xfer        = req_valid_i && req_ready_o;

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = req_addr_i;
    ram_data_o = req_data_i;
    unique case (1'b1)
      rst: ;
      (!rst && state_q == ST_INIT): begin
        ram_cen_o  = 1'b0;
        ram_wen_o  = 1'b0;
        ram_addr_o = init_addr_o;
        ram_data_o = init_data_i;
      end
      (!rst && xfer): begin
        ram_cen_o = 1'b0;
        ram_wen_o = ~req_we_i;
      end
      default: ;
    endcase
  end

`ifdef CABAC_CTX_RSP_REG_EN
  logic              rd2_q;
  logic [DATA_W-1:0] rsp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      rd2_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      rd_q  <= xfer && !req_we_i;
      rd2_q <= rd_q;
      if (rd_q) rsp_q <= ram_data_i;
    end
  end

  assign rsp_valid_o = rd2_q;
  assign rsp_data_o  = rsp_q;
`else
  always_ff @(posedge clk) begin
    if (rst) rd_q <= 1'b0;
    else     rd_q <= xfer && !req_we_i;
  end

  // gated so the bus reads zero outside a response
  assign rsp_valid_o = rd_q;
  assign rsp_data_o  = rd_q ? ram_data_i : '0;
`endif

endmodule
